// File: rtl/msb_priority_encoder_4to2.sv
// rtl/msb_priority_encoder_4to2.sv - MSB-first priority encoder with combinational and registered index outputs
module msb_priority_encoder_4to2 #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] i,
   output logic [W-1:0] y_comb,
   output logic         any_comb,
   output logic [W-1:0] y,
   output logic         valid
);

   logic [W-1:0] y_q;
   logic [W-1:0] y_d;
   logic         valid_q;
   logic         valid_d;

   // Scan upward so the highest set bit writes last and wins; i=0 leaves index 0.
   always_comb begin
      y_comb = '0;
      for (int k = 0; k < N; k++) begin
         if (i[k]) begin
            y_comb = W'(k);
         end
      end
   end

   assign any_comb = |i;

   // Next state: capture the combinational result when enabled, otherwise hold.
   always_comb begin
      y_d     = y_q;
      valid_d = valid_q;
      if (en) begin
         y_d     = y_comb;
         valid_d = any_comb;
      end
   end

   // Registered copy; reset clears it immediately regardless of clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end

   assign y     = y_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_msb_priority_encoder_4to2.sv
// tb/tb_msb_priority_encoder_4to2.sv - directed and random self-checking bench for the MSB priority encoder
module tb_msb_priority_encoder_4to2;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] i;
   logic [1:0] y_comb;
   logic       any_comb;
   logic [1:0] y;
   logic       valid;

   int checks;
   int failures;

   msb_priority_encoder_4to2 #(.N(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .i        (i),
      .y_comb   (y_comb),
      .any_comb (any_comb),
      .y        (y),
      .valid    (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference table for the default 4-bit request vector.
   function automatic logic [1:0] msb_model(input logic [3:0] v);
      casez (v)
         4'b1???: return 2'b11;
         4'b01??: return 2'b10;
         4'b001?: return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      i     = 4'b1111;
      #2;
      checks++;
      if (y !== 2'b00 || valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_initial: y=%b valid=%b required y=00 valid=0", y, valid);
      end
      tick();
      tick();
      checks++;
      if (y !== 2'b00 || valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_held_en: y=%b valid=%b required y=00 valid=0", y, valid);
      end
      checks++;
      if (y_comb !== 2'b11 || any_comb !== 1'b1) begin
         failures++;
         $display("FAIL reset_comb: y_comb=%b any_comb=%b required 11/1", y_comb, any_comb);
      end
      rst_n = 1'b1;
      i     = 4'b0100;
      tick();
      checks++;
      if (y !== 2'b10 || valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_capture: y=%b valid=%b required y=10 valid=1", y, valid);
      end
   endtask

   task automatic test_truth_table();
      logic [3:0] vec [9];
      logic [1:0] exp [9];
      vec = '{4'b0100, 4'b0001, 4'b1001, 4'b0011, 4'b1101, 4'b0101, 4'b0010, 4'b0110, 4'b1100};
      exp = '{2'b10,   2'b00,   2'b11,   2'b01,   2'b11,   2'b10,   2'b01,   2'b10,   2'b11};
      for (int k = 0; k < 9; k++) begin
         i = vec[k];
         #1;
         checks++;
         if (y_comb !== exp[k] || any_comb !== 1'b1) begin
            failures++;
            $display("FAIL truth_table[%0d] i=%b: y_comb=%b any_comb=%b required %b/1",
                     k, vec[k], y_comb, any_comb, exp[k]);
         end
      end
   endtask

   task automatic test_zero();
      en = 1'b1;
      i  = 4'b0000;
      #1;
      checks++;
      if (y_comb !== 2'b00 || any_comb !== 1'b0) begin
         failures++;
         $display("FAIL zero_comb: y_comb=%b any_comb=%b required 00/0", y_comb, any_comb);
      end
      tick();
      checks++;
      if (y !== 2'b00 || valid !== 1'b0) begin
         failures++;
         $display("FAIL zero_reg: y=%b valid=%b required 00/0", y, valid);
      end
      i = 4'b0001;
      tick();
      checks++;
      if (y !== 2'b00 || valid !== 1'b1) begin
         failures++;
         $display("FAIL one_reg: y=%b valid=%b required 00/1", y, valid);
      end
   endtask

   task automatic test_enable();
      en = 1'b1;
      i  = 4'b1000;
      tick();
      checks++;
      if (y !== 2'b11 || valid !== 1'b1) begin
         failures++;
         $display("FAIL enable_capture: y=%b valid=%b required 11/1", y, valid);
      end
      en = 1'b0;
      i  = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (y !== 2'b11 || valid !== 1'b1) begin
            failures++;
            $display("FAIL enable_hold[%0d]: y=%b valid=%b required 11/1", k, y, valid);
         end
      end
      en = 1'b1;
      tick();
      checks++;
      if (y !== 2'b00 || valid !== 1'b1) begin
         failures++;
         $display("FAIL enable_resume: y=%b valid=%b required 00/1", y, valid);
      end
   endtask

   task automatic test_async_reset();
      en = 1'b1;
      i  = 4'b1000;
      tick();
      checks++;
      if (y !== 2'b11 || valid !== 1'b1) begin
         failures++;
         $display("FAIL async_pre: y=%b valid=%b required 11/1", y, valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (y !== 2'b00 || valid !== 1'b0) begin
         failures++;
         $display("FAIL async_assert: y=%b valid=%b required 00/0", y, valid);
      end
      i = 4'b0010;
      tick();
      checks++;
      if (y !== 2'b00 || valid !== 1'b0) begin
         failures++;
         $display("FAIL async_held: y=%b valid=%b required 00/0", y, valid);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (y !== 2'b01 || valid !== 1'b1) begin
         failures++;
         $display("FAIL async_release: y=%b valid=%b required 01/1", y, valid);
      end
   endtask

   task automatic test_random();
      logic [1:0] exp_y;
      logic       exp_v;
      int         errs;
      exp_y = y;
      exp_v = valid;
      errs  = 0;
      for (int k = 0; k < 1000; k++) begin
         i  = 4'($urandom_range(0, 15));
         en = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (y_comb !== msb_model(i) || any_comb !== (i != 4'b0000)) begin
            failures++;
            if (errs < 10)
               $display("FAIL random_comb[%0d] i=%b: y_comb=%b any_comb=%b required %b/%b",
                        k, i, y_comb, any_comb, msb_model(i), (i != 4'b0000));
            errs++;
         end
         if (en) begin
            exp_y = msb_model(i);
            exp_v = (i != 4'b0000);
         end
         tick();
         checks++;
         if (y !== exp_y || valid !== exp_v) begin
            failures++;
            if (errs < 10)
               $display("FAIL random_reg[%0d]: y=%b valid=%b required %b/%b",
                        k, y, valid, exp_y, exp_v);
            errs++;
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      i        = 4'b0000;
      test_reset();
      test_truth_table();
      test_zero();
      test_enable();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
